// File: rtl/axi_trn_pkg.sv
// axi_trn_pkg
//   Shared definitions for the TRN-RX -> AXI4-Stream bridge: TUSER bit
//   positions, TLP fmt/type codes, the input FSM state type, the FIFO
//   sideband record and helpers for non-posted detection and keep generation.
package axi_trn_pkg;

  localparam int TUSER_WIDTH    = 22;
  localparam int TUSER_ERR_BIT  = 1;
  localparam int TUSER_BAR_LSB  = 2;
  localparam int TUSER_SOF_BIT  = 14;
  localparam int SIDEBAND_WIDTH = 10;

  localparam logic [4:0] TYPE_MEM    = 5'b00000;
  localparam logic [4:0] TYPE_MEM_LK = 5'b00001;
  localparam logic [4:0] TYPE_IO     = 5'b00010;
  localparam logic [4:0] TYPE_CFG0   = 5'b00100;
  localparam logic [4:0] TYPE_CFG1   = 5'b00101;

  typedef enum logic {
    ST_IDLE,
    ST_IN_PKT
  } rx_state_t;

  // Per-beat sideband stored next to data and keep in the FIFO.
  typedef struct packed {
    logic       sof;
    logic [6:0] bar_hit;
    logic       err;
    logic       last;
  } rx_side_t;

  // Non-posted: MRd/MRdLk (only without data), IO and Cfg requests.
  function automatic logic is_np(input logic [31:0] hdr_dw0);
    logic [1:0] fmt;
    logic [4:0] tlp_type;
    fmt      = hdr_dw0[30:29];
    tlp_type = hdr_dw0[28:24];
    return (!fmt[1] && (tlp_type == TYPE_MEM || tlp_type == TYPE_MEM_LK)) ||
           (tlp_type == TYPE_IO) ||
           (tlp_type == TYPE_CFG0) || (tlp_type == TYPE_CFG1);
  endfunction

  // Byte-enable mask (up to 128 bits of data) for a beat. Only an eof beat
  // on a multi-DW datapath is partial: rem+1 DWs, packed into the low DWs.
  function automatic logic [15:0] rem2keep(input logic [1:0] rem, input logic eof,
                                           input int n_dw);
    int          valid_dw;
    logic [15:0] keep;
    valid_dw = (eof && n_dw > 1) ? int'(rem) + 1 : n_dw;
    keep = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < valid_dw) keep[4*i +: 4] = 4'hF;
    end
    return keep;
  endfunction

endpackage

// File: rtl/axi_trn_rx_fifo.sv
// axi_trn_rx_fifo
//   Synchronous first-word-fall-through FIFO. The head entry is visible on
//   rd_data whenever count is non-zero; rd_data reads as zero when empty.
//   Ports: clk/rst (sync, active-high), wr_en/wr_data, rd_en/rd_data,
//   count (current occupancy), count_next (occupancy after this edge).
module axi_trn_rx_fifo #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_next
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_rd;

  assign do_rd   = rd_en && (count != '0);
  assign rd_data = (count != '0) ? mem[rd_ptr] : '0;

  always_comb begin
    count_next = count;
    if (wr_en && !do_rd)      count_next = count + CNT_W'(1);
    else if (!wr_en && do_rd) count_next = count - CNT_W'(1);
  end

  // Storage has no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(wr_en && !do_rd && count == CNT_W'(DEPTH)));

endmodule

// File: rtl/axi_trn_rx_bridge.sv
// axi_trn_rx_bridge
//   TRN RX -> AXI4-Stream bridge for the PCIe endpoint. An input FSM polices
//   TRN framing (orphan beats, nested sof, discontinue), beats are DW-swapped
//   and given byte enables, then buffered in an FWFT FIFO feeding AXIS.
//   Ports: user_clk/user_rst (sync, active-high); trn_* TRN RX interface with
//   registered trn_rdst_rdy; m_axis_rx_* AXIS master; np_counter counts
//   delivered non-posted TLPs; proto_err pulses on a framing violation.
module axi_trn_rx_bridge
  import axi_trn_pkg::*;
#(
  parameter int  C_DATA_WIDTH = 64,
  parameter int  FIFO_DEPTH   = 4,
  parameter int  NP_CNT_WIDTH = 3,
  parameter int  TCQ          = 1,
  localparam int REM_WIDTH    = (C_DATA_WIDTH == 128) ? 2 : 1,
  localparam int STRB_WIDTH   = C_DATA_WIDTH / 8
) (
  input  logic                    user_clk,
  input  logic                    user_rst,
  input  logic [C_DATA_WIDTH-1:0] trn_rd,
  input  logic                    trn_rsof,
  input  logic                    trn_reof,
  input  logic                    trn_rsrc_rdy,
  output logic                    trn_rdst_rdy,
  input  logic                    trn_rsrc_dsc,
  input  logic [REM_WIDTH-1:0]    trn_rrem,
  input  logic                    trn_rerrfwd,
  input  logic [6:0]              trn_rbar_hit,
  input  logic                    trn_lnk_up,
  output logic [C_DATA_WIDTH-1:0] m_axis_rx_tdata,
  output logic                    m_axis_rx_tvalid,
  input  logic                    m_axis_rx_tready,
  output logic [STRB_WIDTH-1:0]   m_axis_rx_tkeep,
  output logic                    m_axis_rx_tlast,
  output logic [TUSER_WIDTH-1:0]  m_axis_rx_tuser,
  output logic [NP_CNT_WIDTH-1:0] np_counter,
  output logic                    proto_err
);

  localparam int N_DW       = C_DATA_WIDTH / 32;
  localparam int FIFO_WIDTH = C_DATA_WIDTH + STRB_WIDTH + SIDEBAND_WIDTH;
  localparam int CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1;

  // TCQ is kept for drop-in compatibility; registers carry no modelled delay.
  if (!(C_DATA_WIDTH == 32 || C_DATA_WIDTH == 64 || C_DATA_WIDTH == 128) ||
      FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TCQ < 0) begin : g_param_check
    $error("axi_trn_rx_bridge: unsupported parameter set");
  end

  rx_state_t               state, state_next;
  logic                    accept;
  logic                    wr_en;
  logic [C_DATA_WIDTH-1:0] swapped;
  logic [C_DATA_WIDTH-1:0] wr_data;
  logic [STRB_WIDTH-1:0]   wr_keep;
  rx_side_t                wr_side;
  rx_side_t                rd_side;
  logic [1:0]              rem_ext;
  logic                    proto_err_next;
  logic                    rd_en;
  logic [FIFO_WIDTH-1:0]   rd_word;
  logic [CNT_WIDTH-1:0]    fifo_count;
  logic [CNT_WIDTH-1:0]    fifo_count_next;

  assign accept  = trn_rsrc_rdy && trn_rdst_rdy;
  assign rem_ext = 2'(trn_rrem);

  // TRN carries DW0 in the MS bits, AXIS in the LS bits.
  for (genvar i = 0; i < N_DW; i++) begin : g_dw_swap
    assign swapped[32*i +: 32] = trn_rd[32*(N_DW-1-i) +: 32];
  end

  always_comb begin
    state_next          = state;
    wr_en               = 1'b0;
    wr_data             = swapped;
    wr_keep             = STRB_WIDTH'(rem2keep(rem_ext, trn_reof, N_DW));
    wr_side.sof         = trn_rsof;
    wr_side.bar_hit     = trn_rbar_hit;
    wr_side.err         = trn_rerrfwd;
    wr_side.last        = trn_reof;
    proto_err_next      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (trn_rsof) begin
            wr_en = 1'b1;
            if (!trn_reof) state_next = ST_IN_PKT;
          end else begin
            proto_err_next = 1'b1;
          end
        end
      end
      ST_IN_PKT: begin
        // A discontinue closes the packet even without a beat, so the
        // consumer always sees a terminated, error-flagged packet.
        if (trn_rsrc_dsc) begin
          wr_en        = 1'b1;
          wr_data      = accept ? swapped : '0;
          wr_keep      = '1;
          wr_side.sof  = accept && trn_rsof;
          wr_side.err  = 1'b1;
          wr_side.last = 1'b1;
          state_next   = ST_IDLE;
        end else if (accept) begin
          wr_en = 1'b1;
          if (trn_rsof) proto_err_next = 1'b1;
          if (trn_reof) state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (!trn_lnk_up) state_next = ST_IDLE;
  end

  axi_trn_rx_fifo #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (user_clk),
    .rst        (user_rst),
    .wr_en      (wr_en),
    .wr_data    ({wr_data, wr_keep, wr_side}),
    .rd_en      (rd_en),
    .rd_data    (rd_word),
    .count      (fifo_count),
    .count_next (fifo_count_next)
  );

  assign {m_axis_rx_tdata, m_axis_rx_tkeep, rd_side} = rd_word;
  assign m_axis_rx_tvalid = (fifo_count != '0);
  assign m_axis_rx_tlast  = rd_side.last;
  assign rd_en            = m_axis_rx_tvalid && m_axis_rx_tready;

  always_comb begin
    m_axis_rx_tuser                        = '0;
    m_axis_rx_tuser[TUSER_ERR_BIT]         = rd_side.err;
    m_axis_rx_tuser[TUSER_BAR_LSB +: 7]    = rd_side.bar_hit;
    m_axis_rx_tuser[TUSER_SOF_BIT]         = rd_side.sof;
  end

  // Ready keeps one entry spare: a beat already in flight when ready falls,
  // or a beat-less discontinue, can still be written without overflow.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state        <= ST_IDLE;
      trn_rdst_rdy <= 1'b0;
      proto_err    <= 1'b0;
      np_counter   <= '0;
    end else begin
      state        <= state_next;
      trn_rdst_rdy <= trn_lnk_up && (fifo_count_next <= CNT_WIDTH'(FIFO_DEPTH - 2));
      proto_err    <= proto_err_next;
      if (rd_en && rd_side.sof && is_np(m_axis_rx_tdata[31:0]))
        np_counter <= np_counter + NP_CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_axi_trn_rx_bridge.sv
// tb_axi_trn_rx_bridge
//   Directed bench for axi_trn_rx_bridge. Two instances (64-bit and 128-bit
//   datapath) share the TRN control lines and AXIS ready; each directed step
//   checks the instance relevant to that scenario against hand-computed values.
module tb_axi_trn_rx_bridge;

  logic         user_clk;
  logic         user_rst;
  logic         trn_rsof, trn_reof, trn_rsrc_rdy, trn_rsrc_dsc, trn_rerrfwd, trn_lnk_up;
  logic [6:0]   trn_rbar_hit;
  logic         m_axis_rx_tready;

  logic [63:0]  rd_64;
  logic [0:0]   rrem_64;
  logic         rdst_rdy_64, tvalid_64, tlast_64, proto_err_64;
  logic [63:0]  tdata_64;
  logic [7:0]   tkeep_64;
  logic [21:0]  tuser_64;
  logic [2:0]   np_64;

  logic [127:0] rd_128;
  logic [1:0]   rrem_128;
  logic         rdst_rdy_128, tvalid_128, tlast_128, proto_err_128;
  logic [127:0] tdata_128;
  logic [15:0]  tkeep_128;
  logic [21:0]  tuser_128;
  logic [2:0]   np_128;

  int tests_run    = 0;
  int tests_failed = 0;

  axi_trn_rx_bridge #(.C_DATA_WIDTH(64), .FIFO_DEPTH(4), .NP_CNT_WIDTH(3)) u_dut64 (
    .user_clk         (user_clk),
    .user_rst         (user_rst),
    .trn_rd           (rd_64),
    .trn_rsof         (trn_rsof),
    .trn_reof         (trn_reof),
    .trn_rsrc_rdy     (trn_rsrc_rdy),
    .trn_rdst_rdy     (rdst_rdy_64),
    .trn_rsrc_dsc     (trn_rsrc_dsc),
    .trn_rrem         (rrem_64),
    .trn_rerrfwd      (trn_rerrfwd),
    .trn_rbar_hit     (trn_rbar_hit),
    .trn_lnk_up       (trn_lnk_up),
    .m_axis_rx_tdata  (tdata_64),
    .m_axis_rx_tvalid (tvalid_64),
    .m_axis_rx_tready (m_axis_rx_tready),
    .m_axis_rx_tkeep  (tkeep_64),
    .m_axis_rx_tlast  (tlast_64),
    .m_axis_rx_tuser  (tuser_64),
    .np_counter       (np_64),
    .proto_err        (proto_err_64)
  );

  axi_trn_rx_bridge #(.C_DATA_WIDTH(128), .FIFO_DEPTH(4), .NP_CNT_WIDTH(3)) u_dut128 (
    .user_clk         (user_clk),
    .user_rst         (user_rst),
    .trn_rd           (rd_128),
    .trn_rsof         (trn_rsof),
    .trn_reof         (trn_reof),
    .trn_rsrc_rdy     (trn_rsrc_rdy),
    .trn_rdst_rdy     (rdst_rdy_128),
    .trn_rsrc_dsc     (trn_rsrc_dsc),
    .trn_rrem         (rrem_128),
    .trn_rerrfwd      (trn_rerrfwd),
    .trn_rbar_hit     (trn_rbar_hit),
    .trn_lnk_up       (trn_lnk_up),
    .m_axis_rx_tdata  (tdata_128),
    .m_axis_rx_tvalid (tvalid_128),
    .m_axis_rx_tready (m_axis_rx_tready),
    .m_axis_rx_tkeep  (tkeep_128),
    .m_axis_rx_tlast  (tlast_128),
    .m_axis_rx_tuser  (tuser_128),
    .np_counter       (np_128),
    .proto_err        (proto_err_128)
  );

  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic next_cycle();
    @(posedge user_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic sof, input logic eof, input logic src_rdy,
                               input logic dsc, input logic [1:0] rem,
                               input logic [63:0] d64, input logic [127:0] d128,
                               input logic [6:0] bar);
    trn_rsof     = sof;
    trn_reof     = eof;
    trn_rsrc_rdy = src_rdy;
    trn_rsrc_dsc = dsc;
    rrem_64      = rem[0];
    rrem_128     = rem;
    rd_64        = d64;
    rd_128       = d128;
    trn_rbar_hit = bar;
  endtask

  task automatic drive_idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 64'h0, 128'h0, 7'h0);
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic reset_dut();
    drive_idle();
    user_rst = 1'b1;
    next_cycle();
    user_rst = 1'b0;
    next_cycle();
  endtask

  initial begin
    user_rst         = 1'b1;
    trn_lnk_up       = 1'b1;
    trn_rerrfwd      = 1'b0;
    m_axis_rx_tready = 1'b1;
    drive_idle();
    next_cycle();
    next_cycle();

    $display("[TB] reset state");
    checkOutput("rst_rdst_rdy", rdst_rdy_64, 0);
    checkOutput("rst_tvalid", tvalid_64, 0);
    checkOutput("rst_tlast", tlast_64, 0);
    checkOutput("rst_tkeep", tkeep_64, 0);
    checkOutput("rst_tuser", tuser_64, 0);
    checkOutput("rst_np", np_64, 0);
    checkOutput("rst_proto_err", proto_err_64, 0);
    user_rst = 1'b0;
    next_cycle();
    checkOutput("rdst_rdy_after_rst", rdst_rdy_64, 1);

    $display("[TB] 64b three-beat MWr");
    applyStimulus(1, 0, 1, 0, 2'd0, 64'h4000_0001_0000_000F, 128'h0, 7'h01);
    next_cycle();
    checkOutput("mwr_b0_tvalid", tvalid_64, 1);
    checkOutput("mwr_b0_tdata", tdata_64, 64'h0000_000F_4000_0001);
    checkOutput("mwr_b0_tkeep", tkeep_64, 8'hFF);
    checkOutput("mwr_b0_tuser", tuser_64, 22'h004004);
    checkOutput("mwr_b0_tlast", tlast_64, 0);
    applyStimulus(0, 0, 1, 0, 2'd0, 64'hAAAA_0001_BBBB_0002, 128'h0, 7'h01);
    next_cycle();
    checkOutput("mwr_b1_tdata", tdata_64, 64'hBBBB_0002_AAAA_0001);
    applyStimulus(0, 1, 1, 0, 2'd0, 64'hCCCC_0003_DDDD_0004, 128'h0, 7'h01);
    next_cycle();
    checkOutput("mwr_b2_tdata", tdata_64, 64'hDDDD_0004_CCCC_0003);
    checkOutput("mwr_b2_tkeep", tkeep_64, 8'h0F);
    checkOutput("mwr_b2_tlast", tlast_64, 1);
    checkOutput("mwr_b2_tuser", tuser_64, 22'h000004);
    drive_idle();
    next_cycle();
    checkOutput("mwr_drained", tvalid_64, 0);
    checkOutput("mwr_np", np_64, 0);

    $display("[TB] 128b MRd and np_counter");
    reset_dut();
    applyStimulus(1, 1, 1, 0, 2'd2, 64'h0,
                  {32'h0000_0001, 32'h0000_00FF, 32'h1000_0000, 32'h0}, 7'h00);
    next_cycle();
    checkOutput("mrd_tdata", tdata_128, {32'h0, 32'h1000_0000, 32'h0000_00FF, 32'h0000_0001});
    checkOutput("mrd_tkeep", tkeep_128, 16'h0FFF);
    checkOutput("mrd_tuser", tuser_128, 22'h004000);
    checkOutput("mrd_tlast", tlast_128, 1);
    checkOutput("mrd_np_before", np_128, 0);
    drive_idle();
    next_cycle();
    checkOutput("mrd_np_after", np_128, 1);
    checkOutput("mrd_drained", tvalid_128, 0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 1, 1, 0, 2'd2, 64'h0,
                    {32'h0000_0001, 32'h0000_00FF, 32'h1000_0000, 32'h0}, 7'h00);
      next_cycle();
    end
    drive_idle();
    next_cycle();
    next_cycle();
    checkOutput("np_seven", np_128, 7);
    applyStimulus(1, 1, 1, 0, 2'd2, 64'h0,
                  {32'h0000_0001, 32'h0000_00FF, 32'h1000_0000, 32'h0}, 7'h00);
    next_cycle();
    drive_idle();
    next_cycle();
    checkOutput("np_wrap", np_128, 0);
    applyStimulus(1, 1, 1, 0, 2'd2, 64'h0,
                  {32'h0400_0001, 32'h0000_00FF, 32'h0100_0000, 32'h0}, 7'h00);
    next_cycle();
    drive_idle();
    next_cycle();
    checkOutput("np_cfg", np_128, 1);
    applyStimulus(1, 1, 1, 0, 2'd3, 64'h0,
                  {32'h6000_0001, 32'h0000_00FF, 32'h0, 32'h2000_0000}, 7'h00);
    next_cycle();
    drive_idle();
    next_cycle();
    checkOutput("np_mwr4dw_ignored", np_128, 1);

    $display("[TB] 64b backpressure");
    reset_dut();
    m_axis_rx_tready = 1'b0;
    applyStimulus(1, 0, 1, 0, 2'd0, 64'hB000_0000_C000_0000, 128'h0, 7'h00);
    next_cycle();
    applyStimulus(0, 0, 1, 0, 2'd0, 64'hB000_0001_C000_0001, 128'h0, 7'h00);
    next_cycle();
    checkOutput("bp_rdy_at_two", rdst_rdy_64, 1);
    applyStimulus(0, 0, 1, 0, 2'd0, 64'hB000_0002_C000_0002, 128'h0, 7'h00);
    next_cycle();
    checkOutput("bp_rdy_at_three", rdst_rdy_64, 0);
    checkOutput("bp_head_b0", tdata_64, 64'hC000_0000_B000_0000);
    applyStimulus(0, 1, 1, 0, 2'd1, 64'hB000_0003_C000_0003, 128'h0, 7'h00);
    next_cycle();
    checkOutput("bp_rdy_held", rdst_rdy_64, 0);
    checkOutput("bp_head_stable", tdata_64, 64'hC000_0000_B000_0000);
    m_axis_rx_tready = 1'b1;
    next_cycle();
    checkOutput("bp_release_b1", tdata_64, 64'hC000_0001_B000_0001);
    checkOutput("bp_rdy_back", rdst_rdy_64, 1);
    next_cycle();
    drive_idle();
    checkOutput("bp_b2", tdata_64, 64'hC000_0002_B000_0002);
    next_cycle();
    checkOutput("bp_b3", tdata_64, 64'hC000_0003_B000_0003);
    checkOutput("bp_b3_tlast", tlast_64, 1);
    checkOutput("bp_b3_tkeep", tkeep_64, 8'hFF);
    next_cycle();
    checkOutput("bp_drained", tvalid_64, 0);

    $display("[TB] discontinue");
    reset_dut();
    applyStimulus(1, 0, 1, 0, 2'd0, 64'h4000_0002_1111_1111, 128'h0, 7'h00);
    next_cycle();
    checkOutput("dsc_b0", tdata_64, 64'h1111_1111_4000_0002);
    applyStimulus(0, 0, 1, 1, 2'd0, 64'h2222_2222_3333_3333, 128'h0, 7'h00);
    next_cycle();
    checkOutput("dsc_b1_tdata", tdata_64, 64'h3333_3333_2222_2222);
    checkOutput("dsc_b1_tlast", tlast_64, 1);
    checkOutput("dsc_b1_tuser", tuser_64, 22'h000002);
    checkOutput("dsc_b1_tkeep", tkeep_64, 8'hFF);
    applyStimulus(1, 1, 1, 0, 2'd1, 64'h0000_0001_4444_4444, 128'h0, 7'h00);
    next_cycle();
    checkOutput("dsc_next_tdata", tdata_64, 64'h4444_4444_0000_0001);
    checkOutput("dsc_next_tuser", tuser_64, 22'h004000);
    checkOutput("dsc_next_tlast", tlast_64, 1);
    checkOutput("dsc_next_no_err", proto_err_64, 0);
    drive_idle();
    next_cycle();
    checkOutput("dsc_drained", tvalid_64, 0);

    $display("[TB] framing violations");
    reset_dut();
    applyStimulus(0, 1, 1, 0, 2'd0, 64'h5555_5555_6666_6666, 128'h0, 7'h00);
    next_cycle();
    checkOutput("orphan_dropped", tvalid_64, 0);
    checkOutput("orphan_proto_err", proto_err_64, 1);
    drive_idle();
    next_cycle();
    checkOutput("orphan_pulse_end", proto_err_64, 0);
    applyStimulus(1, 0, 1, 0, 2'd0, 64'h4000_0001_AAAA_AAAA, 128'h0, 7'h00);
    next_cycle();
    applyStimulus(1, 0, 1, 0, 2'd0, 64'h4000_0001_BBBB_BBBB, 128'h0, 7'h00);
    next_cycle();
    checkOutput("nested_sof_tdata", tdata_64, 64'hBBBB_BBBB_4000_0001);
    checkOutput("nested_sof_tuser", tuser_64, 22'h004000);
    checkOutput("nested_sof_err", proto_err_64, 1);
    applyStimulus(0, 1, 1, 0, 2'd0, 64'hCCCC_CCCC_DDDD_DDDD, 128'h0, 7'h00);
    next_cycle();
    checkOutput("nested_eof_tdata", tdata_64, 64'hDDDD_DDDD_CCCC_CCCC);
    checkOutput("nested_eof_tkeep", tkeep_64, 8'h0F);
    checkOutput("nested_err_end", proto_err_64, 0);
    drive_idle();
    next_cycle();

    $display("[TB] link loss");
    reset_dut();
    m_axis_rx_tready = 1'b0;
    applyStimulus(1, 0, 1, 0, 2'd0, 64'h4000_0004_0000_0010, 128'h0, 7'h00);
    next_cycle();
    applyStimulus(0, 0, 1, 0, 2'd0, 64'h0000_0011_0000_0012, 128'h0, 7'h00);
    next_cycle();
    trn_lnk_up = 1'b0;
    applyStimulus(0, 0, 1, 0, 2'd0, 64'h0000_0013_0000_0014, 128'h0, 7'h00);
    next_cycle();
    checkOutput("lnk_rdy_low", rdst_rdy_64, 0);
    checkOutput("lnk_q_b0", tdata_64, 64'h0000_0010_4000_0004);
    drive_idle();
    m_axis_rx_tready = 1'b1;
    next_cycle();
    checkOutput("lnk_q_b1", tdata_64, 64'h0000_0012_0000_0011);
    next_cycle();
    checkOutput("lnk_q_b2", tdata_64, 64'h0000_0014_0000_0013);
    next_cycle();
    checkOutput("lnk_drained", tvalid_64, 0);
    trn_lnk_up = 1'b1;
    next_cycle();
    checkOutput("lnk_rdy_back", rdst_rdy_64, 1);
    applyStimulus(0, 0, 1, 0, 2'd0, 64'h0000_0015_0000_0016, 128'h0, 7'h00);
    next_cycle();
    checkOutput("lnk_fsm_idle", proto_err_64, 1);
    drive_idle();
    next_cycle();

    $display("[TB] reset mid-packet");
    reset_dut();
    m_axis_rx_tready = 1'b0;
    applyStimulus(1, 0, 1, 0, 2'd0, 64'h4000_0002_0000_0020, 128'h0, 7'h00);
    next_cycle();
    checkOutput("midrst_pre_tvalid", tvalid_64, 1);
    drive_idle();
    user_rst = 1'b1;
    next_cycle();
    checkOutput("midrst_tvalid", tvalid_64, 0);
    checkOutput("midrst_rdy", rdst_rdy_64, 0);
    checkOutput("midrst_tkeep", tkeep_64, 0);
    user_rst = 1'b0;
    m_axis_rx_tready = 1'b1;
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
